// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared FSM state encoding and defaults for the hazard controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } ctrl_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX load and ID sources
module load_use_detect #(
  parameter int TAM_DIREC_REG = 5
) (
  input  logic                     i_mem_read_id_ex,
  input  logic [TAM_DIREC_REG-1:0] i_rt_id_ex,
  input  logic [TAM_DIREC_REG-1:0] i_rs_if_id,
  input  logic [TAM_DIREC_REG-1:0] i_rt_if_id,
  output logic                     o_load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign o_load_use = i_mem_read_id_ex && (i_rt_id_ex != '0) &&
                      ((i_rt_id_ex == i_rs_if_id) || (i_rt_id_ex == i_rt_if_id));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/halt control with debug single-step
// Optional stall/flush cycle counter built when STALL_COUNTER_EN is defined.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int TAM_DIREC_REG = 5,
  parameter int TAM_CNT       = 16,
  parameter int DRAIN_CYCLES  = DRAIN_CYCLES_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [TAM_DIREC_REG-1:0] i_rs_if_id,
  input  logic [TAM_DIREC_REG-1:0] i_rt_if_id,
  input  logic [TAM_DIREC_REG-1:0] i_rt_id_ex,
  input  logic                     i_mem_read_id_ex,
  input  logic                     i_branch_taken_ex,
  input  logic                     i_halt_id,
  input  logic                     i_debug_mode,
  input  logic                     i_step,
  output logic                     o_pipe_en,
  output logic                     o_pc_write,
  output logic                     o_if_id_write,
  output logic                     o_id_ex_bubble,
  output logic                     o_if_id_flush,
  output logic                     o_halted,
  output logic [TAM_CNT-1:0]       o_stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_e   state_q, state_d;
  logic [DW-1:0] drn_q, drn_d;
  logic          load_use;
  logic          pipe_en;

  load_use_detect #(
    .TAM_DIREC_REG (TAM_DIREC_REG)
  ) u_load_use_detect (
    .i_mem_read_id_ex (i_mem_read_id_ex),
    .i_rt_id_ex       (i_rt_id_ex),
    .i_rs_if_id       (i_rs_if_id),
    .i_rt_if_id       (i_rt_if_id),
    .o_load_use       (load_use)
  );

  assign pipe_en   = i_debug_mode ? i_step : 1'b1;
  assign o_pipe_en = pipe_en;

  always_comb begin
    state_d        = state_q;
    drn_d          = drn_q;
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    o_halted       = 1'b0;
    case (state_q)
      RUN: begin
        // A taken branch makes the ID instruction wrong-path, so it outranks stall and halt.
        if (i_branch_taken_ex) begin
          o_if_id_flush  = 1'b1;
          o_id_ex_bubble = 1'b1;
        end else if (load_use) begin
          o_pc_write     = 1'b0;
          o_if_id_write  = 1'b0;
          o_id_ex_bubble = 1'b1;
        end else if (i_halt_id) begin
          state_d = DRAIN;
          drn_d   = DW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b1;
        if (drn_q == '0) begin
          state_d = HALTED;
        end else begin
          drn_d = drn_q - DW'(1);
        end
      end
      HALTED: begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_id_ex_bubble = 1'b1;
        o_halted       = 1'b1;
      end
      default: begin
        state_d = RUN;
        drn_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      drn_q   <= '0;
    end else if (pipe_en) begin
      state_q <= state_d;
      drn_q   <= drn_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic               stall_evt;
  logic [TAM_CNT-1:0] cnt_q;

  assign stall_evt = (state_q == RUN) && (i_branch_taken_ex || load_use);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (pipe_en && stall_evt && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TAM_CNT'(1);
    end
  end

  assign o_stall_cnt = cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  localparam int AW = 5;
  localparam int CW = 8;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs, rt, rtx;
  logic          mr, br, hlt, dbg, stp;
  logic          pipe_en, pc_write, if_id_write, bubble, flush, halted;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .TAM_DIREC_REG (AW),
    .TAM_CNT       (CW),
    .DRAIN_CYCLES  (DC)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_rs_if_id        (rs),
    .i_rt_if_id        (rt),
    .i_rt_id_ex        (rtx),
    .i_mem_read_id_ex  (mr),
    .i_branch_taken_ex (br),
    .i_halt_id         (hlt),
    .i_debug_mode      (dbg),
    .i_step            (stp),
    .o_pipe_en         (pipe_en),
    .o_pc_write        (pc_write),
    .o_if_id_write     (if_id_write),
    .o_id_ex_bubble    (bubble),
    .o_if_id_flush     (flush),
    .o_halted          (halted),
    .o_stall_cnt       (stall_cnt)
  );

  typedef struct packed {
    logic          pe;
    logic          pc;
    logic          ifid;
    logic          bub;
    logic          fl;
    logic          hl;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct {
    bit   chk;
    int   cyc;
    out_t exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  // Reference model: remaining drain cycles (0 = not draining), halted flag, event count.
  bit  m_halted = 1'b0;
  int  m_drain  = 0;
  int  m_cnt    = 0;

  task automatic drive(input bit r, input int a_rs, input int a_rt, input int a_rtx,
                       input bit a_mr, input bit a_br, input bit a_hlt,
                       input bit a_dbg, input bit a_stp, input bit chk);
    sb_t e;
    bit  en, lu;
    @(posedge clk);
    #1;
    rst_n = r; rs = AW'(a_rs); rt = AW'(a_rt); rtx = AW'(a_rtx);
    mr = a_mr; br = a_br; hlt = a_hlt; dbg = a_dbg; stp = a_stp;
    en = !a_dbg || a_stp;
    lu = a_mr && (a_rtx != 0) && (a_rtx == a_rs || a_rtx == a_rt);
    e.exp.pe  = en;
    e.exp.hl  = m_halted;
    e.exp.cnt = CW'(m_cnt);
    if (m_halted || m_drain > 0) begin
      e.exp.pc = 0; e.exp.ifid = 0; e.exp.bub = 1; e.exp.fl = 0;
    end else if (a_br) begin
      e.exp.pc = 1; e.exp.ifid = 1; e.exp.bub = 1; e.exp.fl = 1;
    end else if (lu) begin
      e.exp.pc = 0; e.exp.ifid = 0; e.exp.bub = 1; e.exp.fl = 0;
    end else begin
      e.exp.pc = 1; e.exp.ifid = 1; e.exp.bub = 0; e.exp.fl = 0;
    end
    e.chk = chk;
    e.cyc = cyc;
    sb_q.push_back(e);
    if (!r) begin
      m_halted = 0; m_drain = 0; m_cnt = 0;
    end else if (en) begin
      if (m_halted) begin
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else begin
`ifdef STALL_COUNTER_EN
        if ((a_br || lu) && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
        if (!a_br && !lu && a_hlt) m_drain = DC;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    sb_t  e;
    out_t act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          act = {pipe_en, pc_write, if_id_write, bubble, flush, halted, stall_cnt};
          n_cmp++;
          if (act !== e.exp) begin
            n_bad++;
            $display("FAIL outputs cyc=%0d got pe=%b pc=%b ifid=%b bub=%b fl=%b halted=%b cnt=%0d expected pe=%b pc=%b ifid=%b bub=%b fl=%b halted=%b cnt=%0d",
                     e.cyc, act.pe, act.pc, act.ifid, act.bub, act.fl, act.hl, act.cnt,
                     e.exp.pe, e.exp.pc, e.exp.ifid, e.exp.bub, e.exp.fl, e.exp.hl, e.exp.cnt);
          end
        end
      end
    end
  end

  initial begin : stimulus
    // First edge establishes reset state; outputs before it are undefined.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(2);
    // load-use on rs, then on rt, then r0 load (no stall)
    drive(1, 5, 0, 5, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 9, 9, 1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    drive(1, 5, 6, 7, 1, 0, 0, 0, 0, 1);
    // branch outranks load-use and halt
    drive(1, 5, 0, 5, 1, 1, 1, 0, 0, 1);
    idle(1);
    // halt with load-use: stall first, halt accepted next cycle
    drive(1, 3, 0, 3, 1, 0, 1, 0, 0, 1);
    // halt alone: three drain cycles then halted, inputs ignored afterwards
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(1);
    drive(1, 4, 4, 4, 1, 1, 1, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 6; i++)
      drive(1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 1);
    do_reset();
    idle(2);
    // debug single-step with steps on cycles 2, 5, 9, 12
    for (int c = 1; c <= 14; c++)
      drive(1, 0, 0, 0, 0, 0, 1, 1, (c == 2 || c == 5 || c == 9 || c == 12), 1);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 59) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom), 1);
    // continuous stall long enough to reach counter saturation
    do_reset();
    for (int i = 0; i < (1 << CW) + 20; i++) drive(1, 7, 2, 7, 1, 0, 0, 0, 0, 1);
    drive(1, 7, 2, 7, 1, 0, 0, 1, 0, 1);
    idle(1);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d entries left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
